// File: rtl/pwm_motor_driver_if.sv
// Speed-command and PWM-status bundle between the DShot speed handler and the motor driver.
interface pwm_motor_driver_if;
    logic [7:0] speed_in;
    logic       speed_update;
    logic       pwm_out;
    logic [7:0] duty_now;
    logic       failsafe;

    modport master (
        output speed_in, speed_update,
        input  pwm_out, duty_now, failsafe
    );

    modport slave (
        input  speed_in, speed_update,
        output pwm_out, duty_now, failsafe
    );
endinterface

// File: rtl/pwm_motor_driver.sv
// PWM motor driver: period-aligned duty updates, slew-limited acceleration,
// and a command-loss watchdog that forces the motor off.
module pwm_motor_driver #(
    parameter int unsigned PRESCALE       = 4,
    parameter int unsigned RAMP_STEP      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
    input logic              clk,
    input logic              rst,
    pwm_motor_driver_if.slave bus
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
    localparam logic [31:0] WD_MAX    = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] WD_TRIP   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]  STEP      = 9'(RAMP_STEP);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  ramp_q, ramp_d;
    logic [7:0]  duty_q, duty_d;
    logic        pwm_q, pwm_d;
    logic        failsafe_q, failsafe_d;
    logic [31:0] wd_q, wd_d;
    logic        tick, period_end, trip;
    logic [8:0]  ramp_sum;

    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        period_end = tick && (pwm_cnt_q == 8'hFF);
        // An update arriving on the expiry cycle keeps the motor running.
        trip       = !bus.speed_update && (wd_q == WD_TRIP);

        presc_d   = tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pwm_d     = (pwm_cnt_q < duty_q);
        ramp_sum  = {1'b0, ramp_q} + STEP;

        target_d   = target_q;
        ramp_d     = ramp_q;
        duty_d     = duty_q;
        failsafe_d = failsafe_q;
        wd_d       = wd_q;

        if (bus.speed_update) begin
            target_d   = bus.speed_in;
            wd_d       = 32'd0;
            failsafe_d = 1'b0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 32'd1;
        end

        if (trip) begin
            failsafe_d = 1'b1;
            target_d   = 8'd0;
            ramp_d     = 8'd0;
            duty_d     = 8'd0;
        end else if (period_end && !failsafe_q) begin
            // Accelerate in bounded steps; decelerate immediately.
            if (target_q > ramp_q)
                ramp_d = (ramp_sum > {1'b0, target_q}) ? target_q : ramp_sum[7:0];
            else
                ramp_d = target_q;
            duty_d = ramp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            target_q   <= '0;
            ramp_q     <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            failsafe_q <= 1'b1;
            wd_q       <= '0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            target_q   <= target_d;
            ramp_q     <= ramp_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            failsafe_q <= failsafe_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.pwm_out  = pwm_q;
    assign bus.duty_now = duty_q;
    assign bus.failsafe = failsafe_q;

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Directed bench for pwm_motor_driver: two instances (fast ramp/prescale 1 and prescale 3/full step).
module tb_pwm_motor_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_motor_driver_if ifa ();
    pwm_motor_driver_if ifb ();

    pwm_motor_driver #(.PRESCALE(1), .RAMP_STEP(8), .TIMEOUT_CYCLES(2000)) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    pwm_motor_driver #(.PRESCALE(3), .RAMP_STEP(255), .TIMEOUT_CYCLES(2000)) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         keep_en = 1'b0;
    logic [7:0] keep_val = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ifa.speed_update = 1'b0;
        ifb.speed_update = 1'b0;
        cyc++;
        if (keep_en && (cyc % 400 == 0)) begin
            ifa.speed_in     = keep_val;
            ifa.speed_update = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] v);
        keep_val         = v;
        ifa.speed_in     = v;
        ifa.speed_update = 1'b1;
        tick();
    endtask

    task automatic wait_a(output int n);
        logic [7:0] d0;
        d0 = ifa.duty_now;
        n  = 0;
        do begin
            tick();
            n++;
        end while (ifa.duty_now == d0 && n < 600);
    endtask

    task automatic wait_b(output int n);
        logic [7:0] d0;
        d0 = ifb.duty_now;
        n  = 0;
        do begin
            tick();
            n++;
        end while (ifb.duty_now == d0 && n < 800);
    endtask

    initial begin
        int n, hi, dnz, fs0;
        ifa.speed_in = 8'd0; ifa.speed_update = 1'b0;
        ifb.speed_in = 8'd0; ifb.speed_update = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_fs_a",   ifa.failsafe, 1);
        chk("rst_duty_a", ifa.duty_now, 0);
        chk("rst_pwm_a",  ifa.pwm_out,  0);
        chk("rst_fs_b",   ifb.failsafe, 1);
        chk("rst_pwm_b",  ifb.pwm_out,  0);
        rst = 1'b0;

        // No commands: motor stays off
        hi = 0; dnz = 0; fs0 = 0;
        repeat (1000) begin
            tick();
            hi  += int'(ifa.pwm_out);
            dnz += int'(ifa.duty_now != 8'd0);
            fs0 += int'(!ifa.failsafe);
        end
        chk("idle_pwm_high_cycles", hi,  0);
        chk("idle_duty_nonzero",    dnz, 0);
        chk("idle_fs_low_cycles",   fs0, 0);

        // Ramp to 128
        keep_en = 1'b1;
        send(8'd128);
        chk("fs_clear_128", ifa.failsafe, 0);
        for (int k = 1; k <= 16; k++) begin
            wait_a(n);
            chk("ramp128_step", ifa.duty_now, 8 * k);
            if (k > 1) chk("ramp128_gap", n, 256);
        end
        hi = 0;
        repeat (256) begin
            tick();
            hi += int'(ifa.pwm_out);
        end
        chk("duty128_high", hi, 128);

        // Ramp to 200, then immediate stop
        send(8'd200);
        for (int k = 0; k < 20 && ifa.duty_now != 8'd200; k++) wait_a(n);
        chk("reach200", ifa.duty_now, 200);
        send(8'd0);
        wait_a(n);
        chk("stop_duty", ifa.duty_now, 0);
        chk("stop_latency", n, 255);
        hi = 0;
        repeat (256) begin
            tick();
            hi += int'(ifa.pwm_out);
        end
        chk("stop_pwm_high", hi, 0);

        // Two updates in one period: the later one is used (4 < RAMP_STEP)
        send(8'd100);
        send(8'd4);
        wait_a(n);
        chk("last_wins", ifa.duty_now, 4);

        // Full speed, then command loss
        send(8'd255);
        for (int k = 0; k < 40 && ifa.duty_now != 8'd255; k++) wait_a(n);
        chk("reach255", ifa.duty_now, 255);
        keep_en = 1'b0;
        send(8'd255);
        repeat (1999) tick();
        chk("pre_expiry_fs",   ifa.failsafe, 0);
        chk("pre_expiry_duty", ifa.duty_now, 255);
        tick();
        chk("expiry_fs",   ifa.failsafe, 1);
        chk("expiry_duty", ifa.duty_now, 0);
        tick();
        chk("expiry_pwm", ifa.pwm_out, 0);

        // Recovery ramp to 40
        keep_en = 1'b1;
        send(8'd40);
        chk("recover_fs", ifa.failsafe, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_a(n);
            chk("ramp40_step", ifa.duty_now, 8 * k);
        end

        // Update on the exact expiry cycle wins
        keep_en = 1'b0;
        send(8'd40);
        repeat (1999) tick();
        send(8'd40);
        chk("race_fs",   ifa.failsafe, 0);
        chk("race_duty", ifa.duty_now, 40);
        repeat (10) tick();
        chk("race_fs_later",   ifa.failsafe, 0);
        chk("race_duty_later", ifa.duty_now, 40);

        // Prescale 3, full-step ramp: 768-cycle period, 192 high
        ifb.speed_in     = 8'd64;
        ifb.speed_update = 1'b1;
        tick();
        chk("b_fs_clear", ifb.failsafe, 0);
        wait_b(n);
        chk("b_duty", ifb.duty_now, 64);
        hi = 0;
        repeat (768) begin
            tick();
            hi += int'(ifb.pwm_out);
        end
        chk("b_high_cycles", hi, 192);
        n = 0;
        while (!ifb.pwm_out && n < 10) begin
            tick();
            n++;
        end
        chk("b_high_before_rst", ifb.pwm_out, 1);

        // Asynchronous reset mid-high, checked before the next edge
        rst = 1'b1;
        #1;
        chk("async_rst_pwm_b",  ifb.pwm_out,  0);
        chk("async_rst_duty_b", ifb.duty_now, 0);
        chk("async_rst_fs_b",   ifb.failsafe, 1);
        chk("async_rst_duty_a", ifa.duty_now, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
